// File: rtl/dual_port_ram_param.sv
// Dual-port synchronous RAM with registered read ports, optional zero-fill after
// reset, configurable read-during-write behaviour and cross-port collision tracking.
module dual_port_ram_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 6,
    parameter int RDW_MODE      = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_a,
    input  logic                  en_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  valid_a,
    output logic                  valid_b,
    output logic                  busy,
    output logic                  collision,
    output logic [7:0]            coll_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   init_ptr_r;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
    logic                    ready_s;
    logic                    wr_a_s;
    logic                    wr_b_s;
    logic                    coll_s;
    logic [DATA_WIDTH-1:0]   rd_a_s;
    logic [DATA_WIDTH-1:0]   rd_b_s;

    // Next-state logic: the init sweep ends after the last address is cleared
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_ptr_r == LAST_ADDR) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_READY: state_nxt_s = ST_READY;
            default:  state_nxt_s = RESET_STATE;
        endcase
    end

    // Port qualification, collision detect and read-during-write data selection
    always_comb begin
        ready_s = (state_r == ST_READY);
        wr_a_s  = ready_s & en_a & we_a;
        // Port A wins a same-address double write, so B's write is dropped
        wr_b_s  = ready_s & en_b & we_b & ~(wr_a_s & (addr_a == addr_b));
        coll_s  = ready_s & en_a & en_b & (addr_a == addr_b) & (we_a | we_b);
        rd_a_s  = mem_r[addr_a];
        rd_b_s  = mem_r[addr_b];
        if (RDW_MODE != 0) begin
            if (wr_a_s) begin
                rd_a_s = data_a;
            end else if (wr_b_s && (addr_b == addr_a)) begin
                rd_a_s = data_b;
            end else begin
                rd_a_s = mem_r[addr_a];
            end
            if (wr_a_s && (addr_a == addr_b)) begin
                rd_b_s = data_a;
            end else if (wr_b_s) begin
                rd_b_s = data_b;
            end else begin
                rd_b_s = mem_r[addr_b];
            end
        end else begin
            rd_a_s = mem_r[addr_a];
            rd_b_s = mem_r[addr_b];
        end
    end

    // Storage array: zero sweep during init, port writes when ready, untouched by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_r == ST_INIT) begin
                mem_r[init_ptr_r] <= {DATA_WIDTH{1'b0}};
            end else begin
                if (wr_a_s) begin
                    mem_r[addr_a] <= data_a;
                end
                if (wr_b_s) begin
                    mem_r[addr_b] <= data_b;
                end
            end
        end
    end

    // State register, init pointer and busy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= RESET_STATE;
            busy       <= (RESET_STATE == ST_INIT);
            init_ptr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s == ST_INIT);
            if (state_r == ST_INIT) begin
                init_ptr_r <= init_ptr_r + ADDR_WIDTH'(1);
            end
        end
    end

    // Registered read ports; q_x holds its value when the port is idle
    always_ff @(posedge clk) begin
        if (reset) begin
            q_a     <= {DATA_WIDTH{1'b0}};
            q_b     <= {DATA_WIDTH{1'b0}};
            valid_a <= 1'b0;
            valid_b <= 1'b0;
        end else begin
            valid_a <= ready_s & en_a;
            valid_b <= ready_s & en_b;
            if (ready_s && en_a) begin
                q_a <= rd_a_s;
            end
            if (ready_s && en_b) begin
                q_b <= rd_b_s;
            end
        end
    end

    // Collision pulse and saturating collision counter
    always_ff @(posedge clk) begin
        if (reset) begin
            collision  <= 1'b0;
            coll_count <= 8'd0;
        end else begin
            collision <= coll_s;
            if (coll_s && (coll_count != 8'd255)) begin
                coll_count <= coll_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/dual_port_ram_param.md
DUAL_PORT_RAM_PARAM -- requirements
Module: dual_port_ram_param

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 6, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL provide parameter RDW_MODE, default 0, read-during-write result: 0 = old data, 1 = new data.
REQ-004 SHALL provide parameter INIT_ON_RESET, default 1, 1 = zero-fill memory after reset.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 en_a, en_b  in  1 each  port access request.
REQ-008 we_a, we_b  in  1 each  write enable; qualified by en_x.
REQ-009 addr_a, addr_b  in  ADDR_WIDTH each  port address.
REQ-010 data_a, data_b  in  DATA_WIDTH each  write data.
REQ-011 q_a, q_b  out  DATA_WIDTH each  registered read data.
REQ-012 valid_a, valid_b  out  1 each  q_x updated this cycle.
REQ-013 busy  out  1  initialisation in progress; port requests ignored.
REQ-014 collision  out  1  one-cycle pulse, cross-port address conflict.
REQ-015 coll_count  out  8  saturating collision counter.

Function
REQ-016 SHALL implement FSM states INIT and READY; on reset enter INIT if INIT_ON_RESET=1, else READY.
REQ-017 INIT: write 0 to address init_ptr each cycle, init_ptr 0..DEPTH-1; after writing DEPTH-1 go to READY next edge; busy=1 for exactly DEPTH cycles.
REQ-018 During INIT all en_x/we_x SHALL be ignored: no memory write, valid_x=0, no collision.
REQ-019 READY: on an edge with en_x=1, port x SHALL read addr_x and, if we_x=1, write data_x to addr_x.
REQ-020 Read latency SHALL be 1 cycle: q_x and valid_x=1 appear on the edge after the request; both ports independent.
REQ-021 With en_x=0, q_x SHALL hold its last value and valid_x=0.
REQ-022 Same-port write: q_x = previous memory content if RDW_MODE=0, data_x if RDW_MODE=1.
REQ-023 Collision = en_a & en_b & (addr_a==addr_b) & (we_a | we_b), evaluated in READY only.
REQ-024 Both write on collision: port A wins; memory takes data_a; both q_x follow REQ-022 using data_a as the new data.
REQ-025 One write, one read on collision: the reader gets old content (RDW_MODE=0) or writer's data (RDW_MODE=1).
REQ-026 Both read, same address: no collision; both return the stored word.
REQ-027 collision SHALL pulse 1 cycle aligned with valid_x of the colliding access; coll_count increments by 1 per collision and saturates at 255.
REQ-028 Addresses are fully decoded; no wrap or out-of-range case exists.

Reset
REQ-029 On reset edge: q_a=q_b=0, valid_a=valid_b=0, collision=0, coll_count=0, init_ptr=0, busy=INIT_ON_RESET.
REQ-030 Reset mid-INIT SHALL restart init_ptr at 0 and busy SHALL last another full DEPTH cycles.
REQ-031 With INIT_ON_RESET=0, reset SHALL NOT alter memory contents.
REQ-032 Reset SHALL override all same-cycle port requests.

Verification
REQ-033 Defaults, reset 1 cycle -> busy=1 for 64 cycles then 0; reads of addresses 0..63 all return 0x00 with valid=1.
REQ-034 A writes 0x5A at addr 3; next cycle B reads addr 3 -> q_b=0x5A, valid_b=1 one cycle later, collision=0.
REQ-035 Same edge A writes 0x11, B writes 0x22, both addr 5 -> collision pulse, coll_count=1; later read addr 5 -> 0x11.
REQ-036 addr 7 holds 0x33; A writes 0x44 to 7 while B reads 7 -> q_a=q_b=0x33 (RDW_MODE=0), 0x44 (RDW_MODE=1); memory then 0x44.
REQ-037 Reset asserted at INIT cycle 20, with A writing 0xFF to addr 10 during INIT -> busy lasts 64 cycles after reset; addr 10 reads 0x00.
REQ-038 300 consecutive cycles of colliding writes to addr 1 -> coll_count=255 and holds; reset -> 0.
